counter_bank: RTL and testbench

Parametrised multi-channel successor to the single wishbone counter. Provides NCH independent WIDTH-bit up/down counters with compare match, auto-reload, sticky match flags and a combined interrupt, all programmed over the user-area wishbone slave. Count values are exported for the IO pads and LA, and a global freeze input (LA-driven) halts all channels.

---
 rtl/counter_bank.sv | 184 ++++++++++++++++++
 tb/tb_counter_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// counter_bank: NCH independent WIDTH-bit up/down counters with compare match,
// auto-reload, sticky write-1-to-clear match flags and a combined interrupt,
// programmed over a wishbone slave.
// Optional feature macro: COUNTER_BANK_PRESCALE_EN adds a 16-bit PRESCALE
// register at 0x80 driving a tick divider. Without the macro, counters tick
// every clock.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wbs_*           wishbone slave; only wbs_adr_i[7:2] is decoded
//   freeze_i        halts all counting (and the prescale divider)
//   count_o         concatenated counts, channel 0 in the LSBs
//   irq_o           OR over channels of (match flag & irq_en)
module counter_bank #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic                 freeze_i,
  output logic [NCH*WIDTH-1:0] count_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_COMPARE = 2'd1,
    REG_CTRL    = 2'd2,
    REG_STATUS  = 2'd3
  } reg_e;

  logic            acc;
  logic            wr;
  logic            chan_area;
  logic            tick;
  logic [2:0]      ch_sel;
  reg_e            reg_sel;
  logic [31:0]     wmask;
  logic [31:0]     rd_data;
  logic [7:0][31:0] rd_ch;
  logic [7:0]      irq_vec;
  logic            unused_adr;

  // A transfer is taken only while ack is low, giving one ack per two cycles
  // when valid is held.
  assign acc       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr        = acc & wbs_we_i;
  assign chan_area = ~wbs_adr_i[7];
  assign ch_sel    = wbs_adr_i[6:4];
  assign reg_sel   = reg_e'(wbs_adr_i[3:2]);
  assign wmask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign unused_adr = &{1'b0, wbs_adr_i[31:8], wbs_adr_i[1:0]};

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [31:0]      d,
                                             input logic [31:0]      m);
    logic [31:0] r;
    r = (d & m) | (32'(old) & ~m);
    return r[WIDTH-1:0];
  endfunction

`ifdef COUNTER_BANK_PRESCALE_EN
  logic        presc_area;
  logic [15:0] presc_q;
  logic [15:0] div_q;

  assign presc_area = wbs_adr_i[7] & (wbs_adr_i[6:2] == 5'd0);
  assign tick       = (div_q == presc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      div_q   <= '0;
    end else if (wr && presc_area) begin
      presc_q <= wbs_dat_i[15:0];
      div_q   <= '0;
    end else if (!freeze_i) begin
      div_q <= tick ? '0 : div_q + 16'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    if (chan_area)       rd_data = rd_ch[ch_sel];
    else if (presc_area) rd_data = {16'd0, presc_q};
  end
`else
  assign tick = 1'b1;

  always_comb begin
    rd_data = '0;
    if (chan_area) rd_data = rd_ch[ch_sel];
  end
`endif

  // Unimplemented channel slots read 0 so the 3-bit channel index is always
  // in range.
  for (genvar g = 0; g < 8; g++) begin : g_ch
    if (g < NCH) begin : g_on
      logic [WIDTH-1:0] cnt_q;
      logic [WIDTH-1:0] cmp_q;
      logic [WIDTH-1:0] cnt_nxt;
      logic [3:0]       ctrl_q;
      logic             flag_q;
      logic             hit;
      logic             adv;
      logic             match;
      logic [31:0]      rd_val;

      assign hit   = wr & chan_area & (ch_sel == 3'(g));
      assign adv   = tick & ctrl_q[0] & ~freeze_i;
      assign match = ctrl_q[1] ? (cnt_q == '0) : (cnt_q == cmp_q);

      // Reload only replaces the step on the matching tick.
      always_comb begin
        cnt_nxt = cnt_q;
        if (ctrl_q[1])
          cnt_nxt = (match && ctrl_q[2]) ? cmp_q : cnt_q - WIDTH'(1);
        else
          cnt_nxt = (match && ctrl_q[2]) ? '0 : cnt_q + WIDTH'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q  <= '0;
          cmp_q  <= '0;
          ctrl_q <= '0;
          flag_q <= 1'b0;
        end else begin
          if (hit && reg_sel == REG_COUNT)
            cnt_q <= merge(cnt_q, wbs_dat_i, wmask);
          else if (adv)
            cnt_q <= cnt_nxt;
          if (hit && reg_sel == REG_COMPARE)
            cmp_q <= merge(cmp_q, wbs_dat_i, wmask);
          if (hit && reg_sel == REG_CTRL && wbs_sel_i[0])
            ctrl_q <= wbs_dat_i[3:0];
          // A set on the same edge as a clear wins.
          flag_q <= (adv & match) |
                    (flag_q & ~(hit && reg_sel == REG_STATUS && wbs_dat_i[0]));
        end
      end

      always_comb begin
        rd_val = '0;
        case (reg_sel)
          REG_COUNT:   rd_val = 32'(cnt_q);
          REG_COMPARE: rd_val = 32'(cmp_q);
          REG_CTRL:    rd_val = {28'd0, ctrl_q};
          REG_STATUS:  rd_val = {31'd0, flag_q};
          default:     rd_val = '0;
        endcase
      end

      assign rd_ch[g]                   = rd_val;
      assign irq_vec[g]                 = flag_q & ctrl_q[3];
      assign count_o[g*WIDTH +: WIDTH]  = cnt_q;
    end else begin : g_off
      assign rd_ch[g]   = '0;
      assign irq_vec[g] = 1'b0;
    end
  end

  assign irq_o = |irq_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      if (acc) wbs_dat_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: self-checking bench for counter_bank (NCH=4, WIDTH=32).
// Expected read data goes through a scoreboard queue; count/irq values are
// derived from cycle positions relative to each register write.
module tb_counter_bank;
  localparam int unsigned NCH   = 4;
  localparam int unsigned WIDTH = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cyc, stb, we;
  logic [3:0]           sel;
  logic [31:0]          adr, wdat, rdat;
  logic                 ack, freeze, irq;
  logic [NCH*WIDTH-1:0] count;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  counter_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .freeze_i  (freeze),
    .count_o   (count),
    .irq_o     (irq)
  );

  function automatic logic [31:0] chv(input int c);
    return count[c*WIDTH +: WIDTH];
  endfunction

  // Bus driver: drive on a falling edge, expect ack at the next falling edge.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    int lat;
    lat = 0;
    r   = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int n = 1; n <= 4 && lat == 0; n++) begin
      @(negedge clk);
      if (ack) begin
        lat = n;
        r   = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (lat !== 1) $display("FAIL ack_latency adr=%h: got %0d cycles, required 1", a, lat);
    else passes++;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic test_reset;
    logic [31:0] a, r, e;
    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; freeze = 0;
    repeat (3) @(negedge clk);
    checks++; if (count !== '0) $display("FAIL reset_count got=%h exp=0", count); else passes++;
    checks++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else passes++;
    checks++; if (ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", ack); else passes++;
    checks++; if (rdat !== '0) $display("FAIL reset_dat got=%h exp=0", rdat); else passes++;
    rst_n = 1'b1;
    for (int unsigned i = 0; i < NCH*4 + 2; i++) begin
      a = (i < NCH*4) ? 32'(i*4) : ((i == NCH*4) ? 32'h9C : 32'h80);
      exp_q.push_back(32'h0);
      wb_xfer(1'b0, a, '0, 4'hF, r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) $display("FAIL reset_read adr=%h got=%h exp=%h", a, r, e); else passes++;
    end
    checks++; if (irq !== 1'b0) $display("FAIL reset_irq2 got=%b exp=0", irq); else passes++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r, e;
    // Write in flight, reset hits before the acking edge.
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h30; wdat = 32'h55; sel = 4'hF;
    #2 rst_n = 1'b0;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    checks++; if (ack !== 1'b0) $display("FAIL midrst_ack got=%b exp=0", ack); else passes++;
    rst_n = 1'b1;
    // Reset while ack is high.
    @(negedge clk);
    cyc = 1; stb = 1; adr = 32'h00;
    @(negedge clk);
    checks++; if (ack !== 1'b1) $display("FAIL midrst_ack_hi got=%b exp=1", ack); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (ack !== 1'b0) $display("FAIL midrst_ack_drop got=%b exp=0", ack); else passes++;
    cyc = 0; stb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 32'h30, '0, 4'hF, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) $display("FAIL midrst_nowrite got=%h exp=%h", r, e); else passes++;
  endtask

  task automatic test_back_to_back;
    logic e;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h00; sel = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e = (k % 2 == 0);
      checks++;
      if (ack !== e) $display("FAIL b2b_ack k=%0d got=%b exp=%b", k, ack, e); else passes++;
    end
    cyc = 0; stb = 0;
  endtask

  task automatic test_reload;
    logic [31:0] r, e, ec;
    wb_write(32'h14, 32'd5, 4'hF);
    wb_write(32'h18, 32'h5, 4'hF);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      ec = 32'(k % 6);
      checks++;
      if (chv(1) !== ec) $display("FAIL reload_count k=%0d got=%h exp=%h", k, chv(1), ec); else passes++;
      checks++;
      if (irq !== 1'b0) $display("FAIL reload_irq_off k=%0d got=%b exp=0", k, irq); else passes++;
    end
    exp_q.push_back(32'h1);
    wb_xfer(1'b0, 32'h1C, '0, 4'hF, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) $display("FAIL reload_flag got=%h exp=%h", r, e); else passes++;
    wb_write(32'h18, 32'hD, 4'hF);
    checks++; if (irq !== 1'b1) $display("FAIL irq_en got=%b exp=1", irq); else passes++;
    wb_write(32'h18, 32'h8, 4'hF);
    checks++; if (irq !== 1'b1) $display("FAIL irq_hold got=%b exp=1", irq); else passes++;
    wb_write(32'h1C, 32'h1, 4'hF);
    checks++; if (irq !== 1'b0) $display("FAIL irq_w1c got=%b exp=0", irq); else passes++;
  endtask

  task automatic test_down;
    logic [31:0] r, e;
    logic [31:0] seq [4];
    seq = '{32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF};
    wb_write(32'h20, 32'd2, 4'hF);
    wb_write(32'h28, 32'h3, 4'hF);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (chv(2) !== seq[k]) $display("FAIL down_count k=%0d got=%h exp=%h", k, chv(2), seq[k]); else passes++;
    end
    wb_write(32'h28, 32'h0, 4'hF);
    exp_q.push_back(32'h1);
    wb_xfer(1'b0, 32'h2C, '0, 4'hF, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) $display("FAIL down_flag got=%h exp=%h", r, e); else passes++;
    wb_write(32'h2C, 32'h1, 4'hF);
  endtask

  task automatic test_strobe_freeze;
    wb_write(32'h08, 32'h1, 4'hF);
    // Drive cycle sees COUNT=1; the write merges byte 1 into that value.
    wb_write(32'h00, 32'h100, 4'b0010);
    checks++; if (chv(0) !== 32'h101) $display("FAIL strobe_count got=%h exp=00000101", chv(0)); else passes++;
    freeze = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (chv(0) !== 32'h101) $display("FAIL freeze_hold k=%0d got=%h exp=00000101", k, chv(0)); else passes++;
    end
    freeze = 1'b0;
    @(negedge clk);
    checks++; if (chv(0) !== 32'h102) $display("FAIL freeze_release got=%h exp=00000102", chv(0)); else passes++;
    wb_write(32'h08, 32'h0, 4'hF);
  endtask

  task automatic test_range_w1c;
    logic [31:0] r, e;
    logic [31:0] ta [8];
    logic [31:0] te [8];
    ta = '{32'h70, 32'h7C, 32'h84, 32'h00, 32'h20, 32'h24, 32'h14, 32'h3C};
    te = '{32'h0, 32'h0, 32'h0, 32'h104, 32'hFFFF_FFFD, 32'h0, 32'h5, 32'h1};
    wb_write(32'h70, 32'hDEAD_BEEF, 4'hF);
    wb_write(32'h7C, 32'h1, 4'hF);
    wb_write(32'h84, 32'h1234_5678, 4'hF);
    // ch3 matches on every tick (COMPARE=0, reload), so W1C collides with set.
    wb_write(32'h38, 32'h5, 4'hF);
    wb_write(32'h3C, 32'h1, 4'hF);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(te[i]);
      wb_xfer(1'b0, ta[i], '0, 4'hF, r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) $display("FAIL range_read adr=%h got=%h exp=%h", ta[i], r, e); else passes++;
    end
    wb_write(32'h38, 32'h0, 4'hF);
    wb_write(32'h3C, 32'h1, 4'hF);
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 32'h3C, '0, 4'hF, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) $display("FAIL w1c_clear got=%h exp=%h", r, e); else passes++;
  endtask

  task automatic test_prescale;
    logic [31:0] r, e, ec;
    wb_write(32'h80, 32'd3, 4'hF);
    wb_write(32'h38, 32'h1, 4'hF);
`ifdef COUNTER_BANK_PRESCALE_EN
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      ec = 32'((k + 2) / 4);
      checks++;
      if (chv(3) !== ec) $display("FAIL presc_count k=%0d got=%h exp=%h", k, chv(3), ec); else passes++;
    end
    exp_q.push_back(32'd3);
`else
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      ec = 32'(k);
      checks++;
      if (chv(3) !== ec) $display("FAIL presc_count k=%0d got=%h exp=%h", k, chv(3), ec); else passes++;
    end
    exp_q.push_back(32'd0);
`endif
    wb_xfer(1'b0, 32'h80, '0, 4'hF, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) $display("FAIL presc_read got=%h exp=%h", r, e); else passes++;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_back_to_back();
    test_reload();
    test_down();
    test_strobe_freeze();
    test_range_w1c();
    test_prescale();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
